// File: rtl/bus_mem_slave.sv
// Word-addressed RAM responder on the internal CPU bus with programmable wait states.
// Define BUS_MEM_TIMEOUT_EN to abort an unacknowledged done after TIMEOUT cycles.
`ifndef ADDR_SIZE0
`define ADDR_SIZE0 15
`endif
`ifndef DATA_SIZE0
`define DATA_SIZE0 31
`endif

module bus_mem_slave #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    inout  wire [`ADDR_SIZE0:0]  addr,
    inout  wire [`DATA_SIZE0:0]  data,
    inout  wire                  bus_busy,
    input  logic                 read_q,
    input  logic                 write_q,
    input  logic                 read_e,
    input  logic                 write_e,
    output logic                 read_dn,
    output logic                 write_dn,
    output logic                 bus_err
);
    localparam int unsigned DW   = `DATA_SIZE0 + 1;
    localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CMAX = (WAIT_CYCLES > TIMEOUT) ? WAIT_CYCLES : TIMEOUT;
    localparam int unsigned CW   = $clog2(CMAX + 2);

    typedef enum logic [2:0] {StIdle, StWait, StRdDone, StWrDone, StRelease} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic            err_q, err_d;
    logic            armed_q, armed_d;
    logic            capture;
    logic            op_wr_q;
    logic [IW-1:0]   addr_q, idx_in, ram_widx;
    logic [DW-1:0]   wdata_q, ram_wdata;
    logic            ram_we;
    logic            drive_data, drive_busy;
    logic [DW-1:0]   ram [DEPTH];

    assign idx_in  = IW'(addr % DEPTH);
    assign cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            armed_q <= 1'b1;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            armed_q <= armed_d;
            if (capture) begin
                op_wr_q <= write_q;
                addr_q  <= idx_in;
                wdata_q <= data;
            end
        end
    end

    // armed_q enforces one IDLE cycle with both requests low before a new capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        armed_d = armed_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!read_q && !write_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    if (read_q && write_q) begin
                        err_d = 1'b1;
                    end else begin
                        capture = 1'b1;
                        cnt_d   = '0;
                        if (WAIT_CYCLES == 0) state_d = write_q ? StWrDone : StRdDone;
                        else                  state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (op_wr_q ? !write_q : !read_q) begin
                    state_d = StRelease;
                end else if (cnt_inc == CW'(WAIT_CYCLES)) begin
                    state_d = op_wr_q ? StWrDone : StRdDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StRdDone, StWrDone: begin
                if ((state_q == StRdDone) ? read_e : write_e) begin
                    state_d = StRelease;
`ifdef BUS_MEM_TIMEOUT_EN
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    state_d = StRelease;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
`endif
                end
            end
            StRelease: begin
                if (!read_q && !write_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        read_dn    = (state_q == StRdDone);
        write_dn   = (state_q == StWrDone);
        bus_err    = err_q;
        drive_data = (state_q == StRdDone);
        drive_busy = (state_q != StIdle);
    end

    // Commit once on WR_DONE entry; with zero wait states that is the capture edge itself
    assign ram_we    = rst && (state_d == StWrDone) && (state_q != StWrDone);
    assign ram_widx  = (state_q == StIdle) ? idx_in : addr_q;
    assign ram_wdata = (state_q == StIdle) ? data : wdata_q;

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_widx] <= ram_wdata;
    end

    assign data     = drive_data ? ram[addr_q] : {DW{1'bz}};
    assign bus_busy = drive_busy ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed self-checking bench for bus_mem_slave (WAIT_CYCLES=2, DEPTH=256, TIMEOUT=8).
`ifndef ADDR_SIZE0
`define ADDR_SIZE0 15
`endif
`ifndef DATA_SIZE0
`define DATA_SIZE0 31
`endif

module tb_bus_mem_slave;
    localparam int AW = `ADDR_SIZE0 + 1;
    localparam int DW = `DATA_SIZE0 + 1;

    logic clk = 1'b0;
    logic rst;
    logic read_q, write_q, read_e, write_e;
    logic read_dn, write_dn, bus_err;
    logic [AW-1:0] addr_drv;
    logic [DW-1:0] data_drv;
    logic data_en;
    wire [AW-1:0] addr;
    wire [DW-1:0] data;
    wire bus_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign addr = addr_drv;
    assign data = data_en ? data_drv : {DW{1'bz}};

    bus_mem_slave #(
        .DEPTH(256),
        .WAIT_CYCLES(2),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .data(data),
        .bus_busy(bus_busy),
        .read_q(read_q),
        .write_q(write_q),
        .read_e(read_e),
        .write_e(write_e),
        .read_dn(read_dn),
        .write_dn(write_dn),
        .bus_err(bus_err)
    );

    // Released data bus reads as Z (4-state) or 0 (2-state); test words are nonzero
    function automatic logic data_free();
        return $isunknown(data) || (data == '0);
    endfunction

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
        lat = -1;
        addr_drv = a; data_drv = d; data_en = 1'b1; write_q = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (write_dn) begin lat = i; break; end
        end
        write_e = 1'b1; write_q = 1'b0; data_en = 1'b0;
        @(negedge clk);
        write_e = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] val, output int lat,
                            output logic freed);
        lat = -1;
        val = '0;
        addr_drv = a; read_q = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (read_dn) begin lat = i; break; end
        end
        val = data;
        read_e = 1'b1; read_q = 1'b0;
        @(negedge clk);
        freed = data_free() && !read_dn;
        read_e = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (read_dn !== 1'b0) begin errors++; $display("FAIL rst_read_dn got %b want 0", read_dn); end
        checks++; if (write_dn !== 1'b0) begin errors++; $display("FAIL rst_write_dn got %b want 0", write_dn); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err got %b want 0", bus_err); end
        checks++; if (bus_busy === 1'b1) begin errors++; $display("FAIL rst_bus_busy got %b want Z", bus_busy); end
        checks++; if (!data_free()) begin errors++; $display("FAIL rst_data got %h want Z", data); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        addr_drv = 'h5; data_drv = 32'hDEADBEEF; data_en = 1'b1; write_q = 1'b1;
        @(negedge clk);
        checks++; if (write_dn !== 1'b0 || bus_busy !== 1'b1) begin errors++;
            $display("FAIL wr_cyc1 write_dn=%b bus_busy=%b want 0/1", write_dn, bus_busy); end
        @(negedge clk);
        checks++; if (write_dn !== 1'b0 || bus_busy !== 1'b1) begin errors++;
            $display("FAIL wr_cyc2 write_dn=%b bus_busy=%b want 0/1", write_dn, bus_busy); end
        @(negedge clk);
        checks++; if (write_dn !== 1'b1 || bus_busy !== 1'b1) begin errors++;
            $display("FAIL wr_cyc3 write_dn=%b bus_busy=%b want 1/1", write_dn, bus_busy); end
        write_e = 1'b1; write_q = 1'b0; data_en = 1'b0;
        @(negedge clk);
        checks++; if (write_dn !== 1'b0 || bus_busy !== 1'b1) begin errors++;
            $display("FAIL wr_ack write_dn=%b bus_busy=%b want 0/1", write_dn, bus_busy); end
        write_e = 1'b0;
        @(negedge clk);
        checks++; if (bus_busy === 1'b1) begin errors++; $display("FAIL wr_idle_busy got %b want Z", bus_busy); end
        @(negedge clk);
    endtask

    task automatic test_read();
        addr_drv = 'h5; read_q = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (read_dn !== 1'b0) begin errors++; $display("FAIL rd_early got %b want 0", read_dn); end
        @(negedge clk);
        checks++; if (read_dn !== 1'b1 || data !== 32'hDEADBEEF) begin errors++;
            $display("FAIL rd_done read_dn=%b data=%h want 1/deadbeef", read_dn, data); end
        read_e = 1'b1; read_q = 1'b0;
        @(negedge clk);
        checks++; if (read_dn !== 1'b0 || !data_free()) begin errors++;
            $display("FAIL rd_release read_dn=%b data=%h want 0/Z", read_dn, data); end
        read_e = 1'b0;
        @(negedge clk);
        checks++; if (bus_busy === 1'b1) begin errors++; $display("FAIL rd_idle_busy got %b want Z", bus_busy); end
        // Re-raise immediately in the first IDLE cycle: must be ignored
        read_q = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (read_dn !== 1'b0 || bus_busy === 1'b1) begin errors++;
            $display("FAIL b2b_ignored read_dn=%b bus_busy=%b want 0/Z", read_dn, bus_busy); end
        read_q = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v; int lat; logic fr;
        bus_read('h5, v, lat, fr);
        checks++; if (lat != 3 || v !== 32'hDEADBEEF || !fr) begin errors++;
            $display("FAIL b2b_read lat=%0d data=%h freed=%b want 3/deadbeef/1", lat, v, fr); end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] v; int lat; logic fr;
        addr_drv = 'h5; data_drv = 32'h12345678; data_en = 1'b1; read_q = 1'b1; write_q = 1'b1;
        @(negedge clk);
        checks++; if (bus_err !== 1'b1 || bus_busy === 1'b1) begin errors++;
            $display("FAIL sim_err bus_err=%b bus_busy=%b want 1/Z", bus_err, bus_busy); end
        @(negedge clk);
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL sim_pulse got %b want 0", bus_err); end
        repeat (3) @(negedge clk);
        checks++; if (read_dn !== 1'b0 || write_dn !== 1'b0 || bus_err !== 1'b0) begin errors++;
            $display("FAIL sim_nodone rd=%b wr=%b err=%b want 0/0/0", read_dn, write_dn, bus_err); end
        read_q = 1'b0; write_q = 1'b0; data_en = 1'b0;
        @(negedge clk);
        bus_read('h5, v, lat, fr);
        checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("FAIL sim_ram got %h want deadbeef", v); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] v; int lat; logic fr;
        bus_write('h100, 32'h11, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL wrap_wlat got %0d want 3", lat); end
        bus_read('h000, v, lat, fr);
        checks++; if (v !== 32'h11) begin errors++; $display("FAIL wrap_0 got %h want 00000011", v); end
        bus_read('h105, v, lat, fr);
        checks++; if (v !== 32'hDEADBEEF) begin errors++; $display("FAIL wrap_105 got %h want deadbeef", v); end
    endtask

    task automatic test_withdraw();
        logic [DW-1:0] v; int lat; logic fr;
        bus_write('h9, 32'h99, lat);
        addr_drv = 'h9; data_drv = 32'h33; data_en = 1'b1; write_q = 1'b1;
        @(negedge clk);
        write_q = 1'b0; data_en = 1'b0;
        @(negedge clk);
        checks++; if (write_dn !== 1'b0 || bus_busy !== 1'b1) begin errors++;
            $display("FAIL wd_release write_dn=%b bus_busy=%b want 0/1", write_dn, bus_busy); end
        @(negedge clk);
        checks++; if (write_dn !== 1'b0 || bus_busy === 1'b1) begin errors++;
            $display("FAIL wd_idle write_dn=%b bus_busy=%b want 0/Z", write_dn, bus_busy); end
        @(negedge clk);
        bus_read('h9, v, lat, fr);
        checks++; if (v !== 32'h99) begin errors++; $display("FAIL wd_ram got %h want 00000099", v); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] v; int lat; logic fr;
        bus_write('h7, 32'h77, lat);
        addr_drv = 'h7; data_drv = 32'h22; data_en = 1'b1; write_q = 1'b1;
        @(negedge clk);
        checks++; if (bus_busy !== 1'b1) begin errors++; $display("FAIL rm_busy got %b want 1", bus_busy); end
        rst = 1'b0;
        #1;
        checks++; if (bus_busy === 1'b1 || write_dn !== 1'b0 || read_dn !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL rm_async busy=%b wr=%b rd=%b err=%b want Z/0/0/0", bus_busy, write_dn, read_dn, bus_err);
        end
        repeat (2) @(negedge clk);
        write_q = 1'b0; data_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        bus_read('h7, v, lat, fr);
        checks++; if (v !== 32'h77 || lat != 3) begin errors++;
            $display("FAIL rm_ram data=%h lat=%0d want 00000077/3", v, lat); end
    endtask

`ifdef BUS_MEM_TIMEOUT_EN
    task automatic test_timeout();
        int lat; int hi;
        lat = -1; hi = 0;
        addr_drv = 'h5; read_q = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (read_dn) begin lat = i; break; end
        end
        checks++; if (lat != 3) begin errors++; $display("FAIL to_lat got %0d want 3", lat); end
        if (lat > 0) hi = 1;
        for (int i = 0; i < 30 && lat > 0; i++) begin
            @(negedge clk);
            if (read_dn) hi++;
            else break;
        end
        checks++; if (hi != 8) begin errors++; $display("FAIL to_hold got %0d cycles want 8", hi); end
        checks++; if (bus_err !== 1'b1 || read_dn !== 1'b0 || !data_free()) begin errors++;
            $display("FAIL to_abort err=%b rd=%b data=%h want 1/0/Z", bus_err, read_dn, data); end
        read_q = 1'b0;
        @(negedge clk);
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_pulse got %b want 0", bus_err); end
        repeat (2) @(negedge clk);
    endtask
`else
    task automatic test_done_hold();
        int lat; logic seen_err;
        lat = -1; seen_err = 1'b0;
        addr_drv = 'h5; read_q = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (read_dn) begin lat = i; break; end
        end
        repeat (20) begin
            @(negedge clk);
            if (bus_err) seen_err = 1'b1;
        end
        checks++; if (read_dn !== 1'b1 || seen_err || lat != 3) begin errors++;
            $display("FAIL hold_done rd=%b err_seen=%b lat=%0d want 1/0/3", read_dn, seen_err, lat); end
        read_e = 1'b1; read_q = 1'b0;
        @(negedge clk);
        read_e = 1'b0;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b0; read_q = 1'b0; write_q = 1'b0; read_e = 1'b0; write_e = 1'b0;
        addr_drv = '0; data_drv = '0; data_en = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_simultaneous();
        test_wrap();
        test_withdraw();
        test_reset_mid();
`ifdef BUS_MEM_TIMEOUT_EN
        test_timeout();
`else
        test_done_hold();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
